// File: rtl/core_ctrl_pkg.sv
// Shared control types for the soft-riscv phase sequencer.
// State encoding, phase strobe indices and the default memory timeout.
package core_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_MEMORY,
        S_COMMIT,
        S_TRAP
    } state_t;

    localparam int PH_FETCH   = 0;
    localparam int PH_DECODE  = 1;
    localparam int PH_EXECUTE = 2;
    localparam int PH_MEMORY  = 3;
    localparam int PH_COMMIT  = 4;
    localparam int PH_N       = 5;

    localparam int MEM_TIMEOUT_DEF = 16;

    function automatic logic [PH_N-1:0] phase_of(state_t s);
        logic [PH_N-1:0] p;
        p = '0;
        unique case (s)
            S_FETCH:   p[PH_FETCH]   = 1'b1;
            S_DECODE:  p[PH_DECODE]  = 1'b1;
            S_EXECUTE: p[PH_EXECUTE] = 1'b1;
            S_MEMORY:  p[PH_MEMORY]  = 1'b1;
            S_COMMIT:  p[PH_COMMIT]  = 1'b1;
            default:   p = '0;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/handshake_timer.sv
// Loadable down-counter bounding an imem/dmem handshake wait.
// expired is high once CYCLES wait cycles have elapsed since load.
module handshake_timer #(
    parameter int CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic expired
);

    localparam int W = $clog2(CYCLES + 1);
    localparam logic [W-1:0] LOAD_VAL = W'(CYCLES - 1);

    logic [W-1:0] count;

    // reload on wait-state entry, otherwise count down to zero
    always_ff @(posedge clk) begin
        if (rst)
            count <= '0;
        else if (load)
            count <= LOAD_VAL;
        else if (count != '0)
            count <= count - 1'b1;
    end

    assign expired = (count == '0);

endmodule

// File: rtl/phase_sequencer.sv
// Multi-cycle phase FSM: fetch/decode/execute/memory/commit strobes.
// Optional ack timeout trap built when MEM_TIMEOUT_EN is defined.
module phase_sequencer
    import core_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
    parameter int INSTRET_W   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 run,
    input  logic                 imem_ack,
    input  logic                 dmem_ack,
    input  logic                 dec_load,
    input  logic                 dec_store,
    input  logic                 dec_branch,
    input  logic                 dec_jalr,
    input  logic                 dec_illegal,
    input  logic                 dec_rd_we,
    input  logic                 branch_taken,
    output logic                 imem_req,
    output logic                 dmem_req,
    output logic                 phase_fetch,
    output logic                 phase_decode,
    output logic                 phase_execute,
    output logic                 phase_memory,
    output logic                 phase_commit,
    output logic                 pc_offset_en,
    output logic                 pc_override,
    output logic                 rf_we,
    output logic                 trap,
    output logic [INSTRET_W-1:0] instret
);

    state_t state, state_nx;
    logic [PH_N-1:0] phase;
    logic off_now, off_q, ovr_q, rfw_q;
    logic timeout;

`ifdef MEM_TIMEOUT_EN
    logic tmr_load;

    assign tmr_load = (state_nx != state) &&
                      (state_nx == S_FETCH || state_nx == S_MEMORY);

    handshake_timer #(
        .CYCLES(MEM_TIMEOUT)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (tmr_load),
        .expired(timeout)
    );
`else
    // no timer: handshakes wait forever
    assign timeout = (MEM_TIMEOUT < 0);
`endif

    // state register
    always_ff @(posedge clk) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    // next-state decode
    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:
                if (run) state_nx = S_FETCH;
            S_FETCH:
                if (imem_ack)     state_nx = S_DECODE;
                else if (timeout) state_nx = S_TRAP;
            S_DECODE:
                state_nx = dec_illegal ? S_TRAP : S_EXECUTE;
            S_EXECUTE:
                state_nx = (dec_load | dec_store) ? S_MEMORY : S_COMMIT;
            S_MEMORY:
                if (dmem_ack)     state_nx = S_COMMIT;
                else if (timeout) state_nx = S_TRAP;
            S_COMMIT:
                state_nx = run ? S_FETCH : S_IDLE;
            S_TRAP:
                state_nx = S_TRAP;
            default:
                state_nx = S_IDLE;
        endcase
    end

    assign off_now = dec_branch & branch_taken & ~dec_jalr;

    // capture PC mode and writeback at the end of EXECUTE, drop after COMMIT
    always_ff @(posedge clk) begin
        if (rst) begin
            off_q <= 1'b0;
            ovr_q <= 1'b0;
            rfw_q <= 1'b0;
        end else if (state == S_EXECUTE) begin
            off_q <= off_now;
            ovr_q <= dec_jalr;
            rfw_q <= dec_rd_we & ~dec_store;
        end else if (state == S_COMMIT) begin
            off_q <= 1'b0;
            ovr_q <= 1'b0;
            rfw_q <= 1'b0;
        end
    end

    // retired-instruction counter, one per COMMIT cycle
    always_ff @(posedge clk) begin
        if (rst)
            instret <= '0;
        else if (state == S_COMMIT)
            instret <= instret + 1'b1;
    end

    assign phase         = phase_of(state);
    assign phase_fetch   = phase[PH_FETCH];
    assign phase_decode  = phase[PH_DECODE];
    assign phase_execute = phase[PH_EXECUTE];
    assign phase_memory  = phase[PH_MEMORY];
    assign phase_commit  = phase[PH_COMMIT];
    assign imem_req      = phase[PH_FETCH];
    assign dmem_req      = phase[PH_MEMORY];
    assign trap          = (state == S_TRAP);
    assign rf_we         = phase[PH_COMMIT] & rfw_q;
    assign pc_offset_en  = phase[PH_EXECUTE] ? off_now  : off_q;
    assign pc_override   = phase[PH_EXECUTE] ? dec_jalr : ovr_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// Scoreboard bench for phase_sequencer: per-cycle expected outputs are
// queued by the driver and checked by an independent monitor.
module tb_phase_sequencer;

    localparam int IW = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic run = 1'b0;
    logic imem_ack = 1'b0, dmem_ack = 1'b0;
    logic dec_load = 1'b0, dec_store = 1'b0, dec_branch = 1'b0;
    logic dec_jalr = 1'b0, dec_illegal = 1'b0, dec_rd_we = 1'b0;
    logic branch_taken = 1'b0;
    logic imem_req, dmem_req;
    logic phase_fetch, phase_decode, phase_execute;
    logic phase_memory, phase_commit;
    logic pc_offset_en, pc_override, rf_we, trap;
    logic [IW-1:0] instret;

    always #5 clk = ~clk;

    phase_sequencer #(
        .MEM_TIMEOUT(4),
        .INSTRET_W  (IW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .run          (run),
        .imem_ack     (imem_ack),
        .dmem_ack     (dmem_ack),
        .dec_load     (dec_load),
        .dec_store    (dec_store),
        .dec_branch   (dec_branch),
        .dec_jalr     (dec_jalr),
        .dec_illegal  (dec_illegal),
        .dec_rd_we    (dec_rd_we),
        .branch_taken (branch_taken),
        .imem_req     (imem_req),
        .dmem_req     (dmem_req),
        .phase_fetch  (phase_fetch),
        .phase_decode (phase_decode),
        .phase_execute(phase_execute),
        .phase_memory (phase_memory),
        .phase_commit (phase_commit),
        .pc_offset_en (pc_offset_en),
        .pc_override  (pc_override),
        .rf_we        (rf_we),
        .trap         (trap),
        .instret      (instret)
    );

    // {imem_req,dmem_req,F,D,E,M,C,off,ovr,rf_we,trap}
    localparam logic [10:0] O_IDLE = 11'b000_0000_0000;
    localparam logic [10:0] O_F    = 11'b101_0000_0000;
    localparam logic [10:0] O_D    = 11'b000_1000_0000;
    localparam logic [10:0] O_E    = 11'b000_0100_0000;
    localparam logic [10:0] O_M    = 11'b010_0010_0000;
    localparam logic [10:0] O_C    = 11'b000_0001_0000;
    localparam logic [10:0] O_OFF  = 11'b000_0000_1000;
    localparam logic [10:0] O_OVR  = 11'b000_0000_0100;
    localparam logic [10:0] O_RF   = 11'b000_0000_0010;
    localparam logic [10:0] O_TRAP = 11'b000_0000_0001;

    typedef struct {
        logic [10:0]   o;
        logic [IW-1:0] ir;
        string         name;
    } exp_t;

    exp_t sb[$];
    int vectors = 0;
    int errors  = 0;

    // monitor: compare the queued expectation for this cycle mid-cycle
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            logic [10:0] a;
            e = sb.pop_front();
            a = {imem_req, dmem_req, phase_fetch, phase_decode,
                 phase_execute, phase_memory, phase_commit,
                 pc_offset_en, pc_override, rf_we, trap};
            vectors++;
            if (a !== e.o || instret !== e.ir) begin
                errors++;
                $display("FAIL %s: got out=%b instret=%0d, want out=%b instret=%0d",
                         e.name, a, instret, e.o, e.ir);
            end
        end
    end

    // queue this cycle's expectation, then advance one cycle
    task automatic step(input logic [10:0] o, input int ir,
                        input string nm);
        exp_t e;
        e.o = o;
        e.ir = IW'(ir);
        e.name = nm;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        @(posedge clk);
        #1;
        // reset held two cycles
        step(O_IDLE, 0, "reset1");
        rst = 1'b0; run = 1'b1;
        step(O_IDLE, 0, "reset2");
        // ALU op, 1-cycle fetch
        imem_ack = 1'b1;
        step(O_F, 0, "alu_f");
        imem_ack = 1'b0; dec_rd_we = 1'b1;
        step(O_D, 0, "alu_d");
        step(O_E, 0, "alu_e");
        step(O_C | O_RF, 0, "alu_c");
        // taken branch
        imem_ack = 1'b1;
        step(O_F, 1, "br_f");
        imem_ack = 1'b0; dec_rd_we = 1'b0;
        dec_branch = 1'b1; branch_taken = 1'b1;
        step(O_D, 1, "br_d");
        step(O_E | O_OFF, 1, "br_e");
        step(O_C | O_OFF, 1, "br_c");
        // not-taken branch
        imem_ack = 1'b1;
        step(O_F, 2, "nt_f");
        imem_ack = 1'b0; branch_taken = 1'b0;
        step(O_D, 2, "nt_d");
        step(O_E, 2, "nt_e");
        step(O_C, 2, "nt_c");
        // JALR wins over a taken branch
        imem_ack = 1'b1;
        step(O_F, 3, "jalr_f");
        imem_ack = 1'b0; dec_jalr = 1'b1;
        branch_taken = 1'b1; dec_rd_we = 1'b1;
        step(O_D, 3, "jalr_d");
        step(O_E | O_OVR, 3, "jalr_e");
        step(O_C | O_OVR | O_RF, 3, "jalr_c");
        // load: 2-cycle fetch, 3-cycle memory
        dec_jalr = 1'b0; dec_branch = 1'b0; branch_taken = 1'b0;
        step(O_F, 4, "ld_f1");
        imem_ack = 1'b1;
        step(O_F, 4, "ld_f2");
        imem_ack = 1'b0; dec_load = 1'b1;
        step(O_D, 4, "ld_d");
        step(O_E, 4, "ld_e");
        step(O_M, 4, "ld_m1");
        step(O_M, 4, "ld_m2");
        dmem_ack = 1'b1;
        step(O_M, 4, "ld_m3");
        dmem_ack = 1'b0;
        step(O_C | O_RF, 4, "ld_c");
        // store: no register write, then park
        imem_ack = 1'b1;
        step(O_F, 5, "st_f");
        imem_ack = 1'b0; dec_load = 1'b0; dec_store = 1'b1;
        step(O_D, 5, "st_d");
        step(O_E, 5, "st_e");
        dmem_ack = 1'b1;
        step(O_M, 5, "st_m");
        dmem_ack = 1'b0; run = 1'b0;
        step(O_C, 5, "st_c");
        // stray acks while idle
        imem_ack = 1'b1; dmem_ack = 1'b1;
        step(O_IDLE, 6, "park1");
        imem_ack = 1'b0; dmem_ack = 1'b0; run = 1'b1;
        step(O_IDLE, 6, "park2");
        // illegal instruction traps
        imem_ack = 1'b1;
        step(O_F, 6, "ill_f");
        imem_ack = 1'b0; dec_store = 1'b0;
        dec_rd_we = 1'b0; dec_illegal = 1'b1;
        step(O_D, 6, "ill_d");
        dec_illegal = 1'b0; imem_ack = 1'b1;
        step(O_TRAP, 6, "trap1");
        imem_ack = 1'b0; rst = 1'b1;
        step(O_TRAP, 6, "trap2");
        rst = 1'b0;
        step(O_IDLE, 0, "trap_rst");
        // reset during MEMORY, late ack ignored
        imem_ack = 1'b1;
        step(O_F, 0, "mr_f");
        imem_ack = 1'b0; dec_load = 1'b1; dec_rd_we = 1'b1;
        step(O_D, 0, "mr_d");
        step(O_E, 0, "mr_e");
        rst = 1'b1;
        step(O_M, 0, "mr_m");
        rst = 1'b0; run = 1'b0; dmem_ack = 1'b1;
        step(O_IDLE, 0, "mr_idle1");
        dmem_ack = 1'b0;
        step(O_IDLE, 0, "mr_idle2");
        step(O_IDLE, 0, "mr_idle3");
`ifdef MEM_TIMEOUT_EN
        // fetch ack never arrives: trap after 4 FETCH cycles
        dec_load = 1'b0; dec_rd_we = 1'b0; run = 1'b1;
        step(O_IDLE, 0, "to_idle");
        step(O_F, 0, "to_f1");
        step(O_F, 0, "to_f2");
        step(O_F, 0, "to_f3");
        step(O_F, 0, "to_f4");
        step(O_TRAP, 0, "to_trap");
`endif
        for (int i = 0; i < 10 && sb.size() > 0; i++)
            @(posedge clk);
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d pending, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, errors);
        $finish;
    end

endmodule
